// File: rtl/io_input_scanner.sv
// io_input_scanner: round-robin sampler and debouncer for three 32-bit input
// ports. Each port is sampled once per scan round. A port value is accepted
// as stable after DEB consecutive equal samples. Every accepted change raises
// a sticky flag. Reading the port's data word clears that flag.
module io_input_scanner #(
    parameter int DEB = 4
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic        scan_en,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] io_read_data,
    output logic        irq,
    output logic [1:0]  scan_slot
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN0 = 2'd1,
        SCAN1 = 2'd2,
        SCAN2 = 2'd3
    } state_t;

    localparam logic [3:0] DEB_MAX = 4'(DEB);
    localparam logic [3:0] DEB_TH  = 4'(DEB - 1);

    // Word addresses (addr[7:2]) of the readable registers
    localparam logic [5:0] A_PORT0  = 6'h20;
    localparam logic [5:0] A_STATUS = 6'h23;

    state_t            state_q, state_d;
    logic [2:0][31:0]  cand_q, cand_d;
    logic [2:0][3:0]   cnt_q, cnt_d;
    logic [2:0][31:0]  stable_q, stable_d;
    logic [2:0]        chg_q, chg_d;

    logic [2:0][31:0]  port_in;
    logic [5:0]        word_addr;
    logic              unused_addr_bits;

    assign port_in          = {in_port2, in_port1, in_port0};
    assign word_addr        = addr[7:2];
    assign unused_addr_bits = ^{addr[31:8], addr[1:0]};

    // Scan sequencer: rotate through the three ports while enabled, park otherwise
    always_comb begin
        state_d = state_q;
        if (!scan_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SCAN0;
                SCAN0:   state_d = SCAN1;
                SCAN1:   state_d = SCAN2;
                SCAN2:   state_d = SCAN0;
                default: state_d = IDLE;
            endcase
        end
    end

    // Per-port debounce, commit and change-flag update
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        chg_d    = chg_q;
        for (int i = 0; i < 3; i++) begin
            // A data-word read clears the flag; a commit at the same edge overrides it
            if (rd_en && (word_addr == A_PORT0 + 6'(i))) begin
                chg_d[i] = 1'b0;
            end
            if (state_q == state_t'(2'(i + 1))) begin
                if (port_in[i] != cand_q[i]) begin
                    cand_d[i] = port_in[i];
                    cnt_d[i]  = 4'd1;
                end else begin
                    if (cnt_q[i] < DEB_MAX) begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                    // Only a value differing from the accepted one is committed,
                    // so a held value commits exactly once
                    if ((cnt_q[i] >= DEB_TH) && (cand_q[i] != stable_q[i])) begin
                        stable_d[i] = cand_q[i];
                        chg_d[i]    = 1'b1;
                    end
                end
            end
        end
    end

    // State and debounce registers; reset discards all history
    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            chg_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            chg_q    <= chg_d;
        end
    end

    // Combinational read mux
    always_comb begin
        io_read_data = 32'd0;
        case (word_addr)
            A_PORT0:        io_read_data = stable_q[0];
            A_PORT0 + 6'd1: io_read_data = stable_q[1];
            A_PORT0 + 6'd2: io_read_data = stable_q[2];
            A_STATUS:       io_read_data = {28'd0, scan_en, chg_q};
            default:        io_read_data = 32'd0;
        endcase
    end

    assign irq       = |chg_q;
    assign scan_slot = state_q;

endmodule
